// File: rtl/uart_rx_ctrl.sv
// UART receive-path controller: oversample tick, frame sequencing, FWFT byte FIFO.
// Optional idle timeout is built only when RX_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
   parameter int DEPTH = 8,
   parameter int DIV_W = 16,
   parameter int TO_W  = 8
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     rx_en,
   input  logic [DIV_W-1:0]         div,
   input  logic                     clr_status,
   input  logic [7:0]               rsr,
   input  logic                     valid_rx,
   input  logic                     en_rxcnt,
   output logic                     pls_rx,
   output logic [7:0]               rx_data,
   output logic                     rx_valid,
   input  logic                     rx_ready,
   output logic [$clog2(DEPTH):0]   fifo_cnt,
   output logic                     overrun,
   output logic                     frame_abort,
   output logic                     rx_timeout
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

   localparam logic [2:0] S_OFF    = 3'd0;
   localparam logic [2:0] S_IDLE   = 3'd1;
   localparam logic [2:0] S_FRAME  = 3'd2;
   localparam logic [2:0] S_COMMIT = 3'd3;
   localparam logic [2:0] S_DRAIN  = 3'd4;

   logic [2:0]       state;
   logic [2:0]       state_nxt;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] eff_div;
   logic [7:0]       hold;
   logic [7:0]       mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_ptr_nxt;
   logic [AW:0]      count;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             commit;
   logic             ovr_set;
   logic             abort_set;

   // Divisor of zero behaves like one so the tick never stalls.
   assign eff_div = (div == '0) ? DIV_W'(1) : div;

   // Compare with >= so a shrinking divisor wraps on the next cycle.
   assign pls_rx = (state != S_OFF) && (cnt >= eff_div - DIV_W'(1));

   // Oversample tick counter; held at zero while disabled.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (state == S_OFF || !rx_en) begin
         cnt <= '0;
      end else if (pls_rx) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + DIV_W'(1);
      end
   end

   // Frame sequencer next state; disable overrides everything.
   always_comb begin
      state_nxt = state;
      if (!rx_en) begin
         state_nxt = S_OFF;
      end else begin
         unique case (state)
            S_OFF:    state_nxt = S_IDLE;
            S_IDLE:   if (en_rxcnt) state_nxt = S_FRAME;
            S_FRAME: begin
               if (valid_rx)       state_nxt = S_COMMIT;
               else if (!en_rxcnt) state_nxt = S_IDLE;
            end
            S_COMMIT: state_nxt = S_DRAIN;
            S_DRAIN:  if (!en_rxcnt) state_nxt = S_IDLE;
            default:  state_nxt = S_OFF;
         endcase
      end
   end

   // Frame sequencer state register.
   always_ff @(posedge clk) begin
      if (!rstn) state <= S_OFF;
      else       state <= state_nxt;
   end

   // Capture the received byte on the first STOP cycle only.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         hold <= '0;
      end else if (rx_en && state == S_FRAME && valid_rx) begin
         hold <= rsr;
      end
   end

   assign empty     = (count == '0);
   assign full      = (count == FULL_CNT);
   assign rx_valid  = !empty;
   assign fifo_cnt  = count;
   assign pop       = rx_valid && rx_ready;
   assign commit    = rx_en && (state == S_COMMIT);
   assign push      = commit && (!full || pop);
   assign ovr_set   = commit && full && !pop;
   assign abort_set = rx_en && (state == S_FRAME) && !valid_rx && !en_rxcnt;
   assign rd_ptr_nxt = rd_ptr + AW'(1);

   // FIFO storage; no reset needed, the head register guards reads.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= hold;
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr_nxt;
         unique case ({push, pop})
            2'b10:   count <= count + ONE_CNT;
            2'b01:   count <= count - ONE_CNT;
            default: count <= count;
         endcase
      end
   end

   // Registered head so the output holds its last byte when empty.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rx_data <= '0;
      end else if (push && (empty || (pop && count == ONE_CNT))) begin
         rx_data <= hold;
      end else if (pop && count > ONE_CNT) begin
         rx_data <= mem[rd_ptr_nxt];
      end
   end

   // Sticky overrun; a new loss beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (!rstn)           overrun <= 1'b0;
      else if (ovr_set)    overrun <= 1'b1;
      else if (clr_status) overrun <= 1'b0;
   end

   // Sticky frame abort; a new abort beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (!rstn)           frame_abort <= 1'b0;
      else if (abort_set)  frame_abort <= 1'b1;
      else if (clr_status) frame_abort <= 1'b0;
   end

`ifdef RX_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt;
   logic            to_clr;

   assign to_clr     = push || pop || (state != S_IDLE) || !rx_en;
   assign rx_timeout = &to_cnt;

   // Idle timeout: counts ticks while data waits unread, saturating.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         to_cnt <= '0;
      end else if (to_clr) begin
         to_cnt <= '0;
      end else if (pls_rx && !empty && !rx_timeout) begin
         to_cnt <= to_cnt + TO_W'(1);
      end
   end
`else
   logic [TO_W-1:0] to_cnt;

   assign to_cnt     = '0;
   assign rx_timeout = &to_cnt;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl.
// Bytes expected downstream are queued when frames are driven.
module tb_uart_rx_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        rx_en;
   logic [15:0] div;
   logic        clr_status;
   logic [7:0]  rsr;
   logic        valid_rx;
   logic        en_rxcnt;
   logic        pls_rx;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [3:0]  fifo_cnt;
   logic        overrun;
   logic        frame_abort;
   logic        rx_timeout;

   int          n_chk = 0;
   int          n_err = 0;
   logic [7:0]  sb_q [$];

   always #5 clk = ~clk;

   uart_rx_ctrl #(.DEPTH(8), .DIV_W(16), .TO_W(4)) dut (
      .clk(clk), .rstn(rstn), .rx_en(rx_en), .div(div),
      .clr_status(clr_status), .rsr(rsr), .valid_rx(valid_rx),
      .en_rxcnt(en_rxcnt), .pls_rx(pls_rx), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .fifo_cnt(fifo_cnt),
      .overrun(overrun), .frame_abort(frame_abort),
      .rx_timeout(rx_timeout)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      en_rxcnt = 1'b1;
      tick(3);
      rsr      = b;
      valid_rx = 1'b1;
      tick(3);
      valid_rx = 1'b0;
      en_rxcnt = 1'b0;
      tick(2);
   endtask

   // Every pop is compared against the oldest queued byte.
   always @(negedge clk) begin
      if (rstn && rx_valid && rx_ready) begin
         if (sb_q.size() == 0) check("pop_unexpected", 32'd1, 32'd0);
         else check("pop_data", 32'(rx_data), 32'(sb_q.pop_front()));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0; rx_en = 1'b0; div = 16'd4; clr_status = 1'b0;
      rsr = 8'h00; valid_rx = 1'b0; en_rxcnt = 1'b0; rx_ready = 1'b0;
      tick(3);
      check("rst_pls", 32'(pls_rx), 0);
      check("rst_data", 32'(rx_data), 0);
      check("rst_valid", 32'(rx_valid), 0);
      check("rst_cnt", 32'(fifo_cnt), 0);
      check("rst_ovr", 32'(overrun), 0);
      check("rst_abort", 32'(frame_abort), 0);
      check("rst_to", 32'(rx_timeout), 0);
      rstn = 1'b1;
      tick(2);
      check("off_pls", 32'(pls_rx), 0);

      // tick generator
      rx_en = 1'b1;
      tick(1);
      for (int i = 0; i < 8; i++) begin
         check("pls_div4", 32'(pls_rx), 32'((i % 4) == 3));
         tick(1);
      end
      div = 16'd0;
      #1;
      for (int i = 0; i < 4; i++) begin
         check("pls_div0", 32'(pls_rx), 1);
         tick(1);
      end
      div = 16'd4;
      tick(1);

      // single frame, commit latency
      en_rxcnt = 1'b1;
      tick(20);
      rsr = 8'hA5; valid_rx = 1'b1;
      tick(1);
      check("commit_valid0", 32'(rx_valid), 0);
      tick(1);
      check("push_valid", 32'(rx_valid), 1);
      check("push_data", 32'(rx_data), 32'h A5);
      check("push_cnt", 32'(fifo_cnt), 1);
      sb_q.push_back(8'hA5);
      tick(1);
      valid_rx = 1'b0; en_rxcnt = 1'b0;
      tick(2);
      check("one_push_cnt", 32'(fifo_cnt), 1);
      rx_ready = 1'b1;
      tick(2);
      rx_ready = 1'b0;
      check("drain1_cnt", 32'(fifo_cnt), 0);

      // overflow
      for (int i = 0; i < 9; i++) begin
         send(8'(i));
         if (i < 8) sb_q.push_back(8'(i));
      end
      check("full_cnt", 32'(fifo_cnt), 8);
      check("full_ovr", 32'(overrun), 1);
      check("full_head", 32'(rx_data), 0);
      rx_ready = 1'b1;
      tick(10);
      rx_ready = 1'b0;
      check("drain_cnt", 32'(fifo_cnt), 0);
      check("drain_sb", 32'(sb_q.size()), 0);
      check("empty_hold", 32'(rx_data), 7);
      clr_status = 1'b1;
      tick(1);
      clr_status = 1'b0;
      check("ovr_clr", 32'(overrun), 0);

      // push and pop at full in the commit cycle
      for (int i = 0; i < 8; i++) begin
         send(8'(i));
         sb_q.push_back(8'(i));
      end
      en_rxcnt = 1'b1;
      tick(3);
      rsr = 8'h08; valid_rx = 1'b1;
      tick(1);
      rx_ready = 1'b1;
      sb_q.push_back(8'h08);
      tick(1);
      rx_ready = 1'b0;
      check("pp_cnt", 32'(fifo_cnt), 8);
      check("pp_ovr", 32'(overrun), 0);
      check("pp_head", 32'(rx_data), 1);
      tick(1);
      valid_rx = 1'b0; en_rxcnt = 1'b0;
      tick(2);
      rx_ready = 1'b1;
      tick(10);
      rx_ready = 1'b0;
      check("pp_drain", 32'(fifo_cnt), 0);

      // frame abort
      en_rxcnt = 1'b1;
      tick(3);
      en_rxcnt = 1'b0;
      tick(1);
      check("abort_set", 32'(frame_abort), 1);
      check("abort_cnt", 32'(fifo_cnt), 0);
      en_rxcnt = 1'b1;
      tick(3);
      en_rxcnt = 1'b0; clr_status = 1'b1;
      tick(1);
      clr_status = 1'b0;
      check("abort_win", 32'(frame_abort), 1);
      clr_status = 1'b1;
      tick(1);
      clr_status = 1'b0;
      check("abort_clr", 32'(frame_abort), 0);

      // disable mid-frame
      send(8'h5A);
      sb_q.push_back(8'h5A);
      en_rxcnt = 1'b1;
      tick(3);
      rx_en = 1'b0;
      tick(1);
      rsr = 8'hEE; valid_rx = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("off_pls_low", 32'(pls_rx), 0);
         tick(1);
      end
      valid_rx = 1'b0; en_rxcnt = 1'b0;
      tick(1);
      check("off_cnt", 32'(fifo_cnt), 1);
      check("off_data", 32'(rx_data), 32'h5A);
      check("off_abort", 32'(frame_abort), 0);
      check("off_ovr", 32'(overrun), 0);

      // idle timeout
      div = 16'd1;
      rx_en = 1'b1;
      tick(1);
      tick(14);
      check("to_early", 32'(rx_timeout), 0);
      tick(1);
`ifdef RX_TIMEOUT_EN
      check("to_set", 32'(rx_timeout), 1);
      tick(3);
      check("to_hold", 32'(rx_timeout), 1);
`else
      check("to_tied", 32'(rx_timeout), 0);
`endif
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      check("to_clr", 32'(rx_timeout), 0);
      check("end_cnt", 32'(fifo_cnt), 0);
      check("sb_empty", 32'(sb_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
